// File: rtl/bus_ctrl16.sv
// Memory-bus controller for the 16-bit system: decodes CPU accesses into regions,
// inserts per-region wait states, registers read data and flags unmapped accesses.
module bus_ctrl16 #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {16'hf000, 16'h3000, 16'h2000, 16'h0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {16'hf000, 16'hff00, 16'hff00, 16'hf000},
    parameter logic [NUM_SLAVES*4-1:0]          SLAVE_WAIT = {4'd1, 4'd1, 4'd1, 4'd1},
    parameter logic [DATA_WIDTH-1:0]            DEFAULT_RDATA = 16'h0000
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             cpu_valid,
    input  logic [ADDR_WIDTH-1:0]            cpu_addr,
    input  logic [DATA_WIDTH-1:0]            cpu_wdata,
    input  logic                             cpu_we,
    output logic                             cpu_ready,
    output logic [DATA_WIDTH-1:0]            cpu_rdata,
    output logic [ADDR_WIDTH-1:0]            slave_addr,
    output logic [DATA_WIDTH-1:0]            slave_wdata,
    output logic [NUM_SLAVES-1:0]            slave_sel,
    output logic                             slave_we,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slave_rdata,
    output logic                             bus_err,
    output logic [ADDR_WIDTH-1:0]            err_addr,
    input  logic                             err_clr,
    output logic [1:0]                       dbg_state
);

    // Handshake: the CPU holds cpu_valid with stable addr/data/we until it sees the
    // one-cycle cpu_ready pulse; the controller never samples a request during RESP.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic [2:0]      r_idx;
    logic            r_we;

    logic            w_hit;
    logic [2:0]      w_idx;
    logic [3:0]      w_wait;
    logic [DATA_WIDTH-1:0] w_rsel;

    // Scan from the top slot down so the lowest matching index is the one kept.
    always_comb begin
        w_hit = 1'b0;
        w_idx = 3'd0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((cpu_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                w_hit = 1'b1;
                w_idx = 3'(i);
            end
        end
    end

    assign w_wait    = SLAVE_WAIT[w_idx*4 +: 4];
    assign w_rsel    = slave_rdata[r_idx*DATA_WIDTH +: DATA_WIDTH];
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_idx       <= 3'd0;
            r_we        <= 1'b0;
            cpu_ready   <= 1'b0;
            cpu_rdata   <= '0;
            slave_addr  <= '0;
            slave_wdata <= '0;
            slave_sel   <= '0;
            slave_we    <= 1'b0;
            bus_err     <= 1'b0;
            err_addr    <= '0;
        end else begin
            cpu_ready <= 1'b0;
            slave_we  <= 1'b0;
            if (err_clr) begin
                bus_err  <= 1'b0;
                err_addr <= '0;
            end
            case (r_state)
                S_IDLE: begin
                    if (cpu_valid) begin
                        slave_addr  <= cpu_addr;
                        slave_wdata <= cpu_wdata;
                        r_we        <= cpu_we;
                        r_idx       <= w_idx;
                        if (w_hit) begin
                            slave_sel <= NUM_SLAVES'(1) << w_idx;
                            r_cnt     <= w_wait;
                            slave_we  <= cpu_we && (w_wait == 4'd0);
                            r_state   <= S_ACCESS;
                        end else begin
                            // A same-cycle clear loses to the new error, which then records its address.
                            cpu_rdata <= DEFAULT_RDATA;
                            bus_err   <= 1'b1;
                            if (!bus_err || err_clr) begin
                                err_addr <= cpu_addr;
                            end
                            cpu_ready <= 1'b1;
                            r_state   <= S_RESP;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt    <= r_cnt - 4'd1;
                        slave_we <= r_we && (r_cnt == 4'd1);
                    end else begin
                        cpu_rdata <= w_rsel;
                        slave_sel <= '0;
                        cpu_ready <= 1'b1;
                        r_state   <= S_RESP;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
